mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencing controller between the EX/MEM pipeline register and the data memory of the LC2K CPU. Accepts one load or store request per handshake, drives the memory's address, store data and access/write controls for a fixed number of cycles, captures the load result, and hands a completion record to writeback. Out-of-range addresses are trapped before reaching the memory.

## Interface
- ADDR_DEPTH, 64, number of valid memory words; addresses ≥ ADDR_DEPTH fault.
- WAIT_CYCLES, 2, cycles the memory controls are held per access; legal range 1..15.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- reqValid  in  1  upstream request present.
- reqReady  out  1  controller can accept a request this cycle.
- reqAddr  in  32  word address (ALU result).
- reqData  in  32  store data (regB value).
- reqWrite  in  1  1 = store (sw), 0 = load (lw).
- reqDest  in  3  destination register for loads.
- memAddr  out  32  address to data memory.
- memWData  out  32  store data to data memory.
- CONTROL_MEM_ACCESS  out  1  memory access strobe.
- CONTROL_ENABLE_MEM_WRITE  out  1  1 = write, 0 = read.
- memRData  in  32  memory read result.
- wbValid  out  1  completion record present.
- wbReady  in  1  writeback accepts the record.
- wbData  out  32  load data; 0 for stores and faults.
- wbDest  out  3  latched reqDest.
- wbIsLoad  out  1  1 if record is a load.
- memFault  out  1  1 if record is an out-of-range access.

## Operation
- States: IDLE, ACCESS, RESP. Reset → IDLE.
- reqReady = (IDLE) or (RESP and wbReady); combinational; 0 while rst_n low.
- Request accepted on an edge where reqValid & reqReady; latch addr, data, write, dest.
- Accept with reqAddr < ADDR_DEPTH (unsigned 32-bit compare): → ACCESS; memAddr/memWData loaded; CONTROL_MEM_ACCESS=1; CONTROL_ENABLE_MEM_WRITE=reqWrite; counter=WAIT_CYCLES-1.
- Accept with reqAddr ≥ ADDR_DEPTH: → RESP directly; no strobe ever asserted; memFault=1, wbData=0, wbIsLoad=reqWrite inverted.
- ACCESS: memAddr, memWData, both controls held constant. Edge with counter≠0: decrement. Edge with counter=0: wbData ← memRData for loads, 0 for stores; both controls ← 0; wbValid ← 1; → RESP.
- RESP: wbValid and all wb* fields held stable until wbReady. Handshake edge: if a new request is accepted same edge, proceed as from IDLE (back-to-back, no bubble); else wbValid ← 0, → IDLE.
- memAddr/memWData retain last values outside ACCESS; only controls gate the memory.
- All outputs registered except reqReady.

## Timing
- Reset values: wbValid 0, wbData 0, wbDest 0, wbIsLoad 0, memFault 0, memAddr 0, memWData 0, CONTROL_MEM_ACCESS 0, CONTROL_ENABLE_MEM_WRITE 0, counter 0.
- rst_n low at any edge (including mid-ACCESS or RESP with wbReady low): state → IDLE, all above cleared that edge; in-flight request discarded, no completion issued; a store already strobed may have written.
- Valid access accepted at edge N: controls high cycles N+1..N+WAIT_CYCLES; wbValid high from edge N+WAIT_CYCLES.
- Fault accepted at edge N: wbValid high from edge N+1 cycle (after edge N).
- Throughput with wbReady held 1: one access per WAIT_CYCLES+1 cycles... per accept-to-accept = WAIT_CYCLES+1 edges.
- reqValid while reqReady=0: ignored; upstream must hold fields stable.

## Test plan
- Load, memory model Data[10]=5, WAIT_CYCLES=2: req addr=10, write=0, dest=3 at edge 0 → controls high cycles 1–2, write=0; wbValid at edge 2 with wbData=5, wbDest=3, wbIsLoad=1, memFault=0.
- Store then load: sw addr=11 data=0xDEADBEEF → CONTROL_ENABLE_MEM_WRITE=1 for 2 cycles, wbIsLoad=0, wbData=0; following lw addr=11 → wbData=0xDEADBEEF.
- Fault: req addr=64 (and 0xFFFFFFFF) → strobes never rise, wbValid next edge with memFault=1, wbData=0.
- Backpressure: wbReady low 5 cycles in RESP → wb* stable, reqReady=0, new reqValid ignored; wbReady high with reqValid → accepted same edge, next access starts without IDLE bubble.
- Reset mid-ACCESS: rst_n low during cycle 1 of a load → next edge controls 0, wbValid 0, state IDLE; no completion appears after rst_n returns high.
- WAIT_CYCLES=1 and 15 builds: controls held exactly 1 / 15 cycles; load of addr=10 returns 5.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequencing controller between the EX/MEM pipeline register and the LC2K data
// memory. Accepts one load/store per handshake, holds the memory address, store
// data and access/write strobes for WAIT_CYCLES cycles, captures load data and
// presents a completion record to writeback. Addresses >= ADDR_DEPTH are
// trapped and never reach the memory.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqValid/reqReady          request handshake (reqReady is combinational)
//   reqAddr/reqData            word address and store data
//   reqWrite/reqDest           1 = store, destination register for loads
//   memAddr/memWData           address / store data to data memory
//   CONTROL_MEM_ACCESS         memory access strobe
//   CONTROL_ENABLE_MEM_WRITE   1 = write, 0 = read
//   memRData                   memory read result
//   wbValid/wbReady            completion handshake
//   wbData/wbDest              load data (0 for stores/faults), destination
//   wbIsLoad/memFault          record is a load / record is out of range
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned ADDR_DEPTH  = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqData,
    input  logic        reqWrite,
    input  logic [2:0]  reqDest,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic        CONTROL_MEM_ACCESS,
    output logic        CONTROL_ENABLE_MEM_WRITE,
    input  logic [31:0] memRData,
    output logic        wbValid,
    input  logic        wbReady,
    output logic [31:0] wbData,
    output logic [2:0]  wbDest,
    output logic        wbIsLoad,
    output logic        memFault
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_access_q, mem_access_d;
    logic                mem_write_q, mem_write_d;
    logic                wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DEST_W-1:0]   wb_dest_q, wb_dest_d;
    logic                wb_is_load_q, wb_is_load_d;
    logic                mem_fault_q, mem_fault_d;

    logic                accept_c;
    logic                in_range_c;

    // Ready in IDLE, or in RESP on the cycle writeback takes the record.
    assign reqReady   = rst_n && ((state_q == IDLE) || ((state_q == RESP) && wbReady));
    assign accept_c   = reqValid && reqReady;
    assign in_range_c = reqAddr < DATA_W'(ADDR_DEPTH);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_access_q <= 1'b0;
            mem_write_q  <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_dest_q    <= '0;
            wb_is_load_q <= 1'b0;
            mem_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_access_q <= mem_access_d;
            mem_write_q  <= mem_write_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_dest_q    <= wb_dest_d;
            wb_is_load_q <= wb_is_load_d;
            mem_fault_q  <= mem_fault_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_access_d = mem_access_q;
        mem_write_d  = mem_write_q;
        wb_valid_d   = wb_valid_q;
        wb_data_d    = wb_data_q;
        wb_dest_d    = wb_dest_q;
        wb_is_load_d = wb_is_load_q;
        mem_fault_d  = mem_fault_q;

        case (state_q)
            IDLE: begin
                // Only leaves on an accept, handled below.
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Final access cycle: memRData is valid while the strobe is still up.
                    wb_data_d    = mem_write_q ? '0 : memRData;
                    mem_access_d = 1'b0;
                    mem_write_d  = 1'b0;
                    wb_valid_d   = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (wbReady) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept overrides the RESP drain so back-to-back requests see no bubble.
        if (accept_c) begin
            wb_dest_d    = reqDest;
            wb_is_load_d = !reqWrite;
            if (in_range_c) begin
                state_d      = ACCESS;
                mem_addr_d   = reqAddr;
                mem_wdata_d  = reqData;
                mem_access_d = 1'b1;
                mem_write_d  = reqWrite;
                cnt_d        = CNT_W'(WAIT_CYCLES - 1);
                wb_valid_d   = 1'b0;
                wb_data_d    = '0;
                mem_fault_d  = 1'b0;
            end else begin
                // Trapped access: memory controls are never raised.
                state_d     = RESP;
                wb_valid_d  = 1'b1;
                wb_data_d   = '0;
                mem_fault_d = 1'b1;
            end
        end
    end

    assign memAddr                  = mem_addr_q;
    assign memWData                 = mem_wdata_q;
    assign CONTROL_MEM_ACCESS       = mem_access_q;
    assign CONTROL_ENABLE_MEM_WRITE = mem_write_q;
    assign wbValid                  = wb_valid_q;
    assign wbData                   = wb_data_q;
    assign wbDest                   = wb_dest_q;
    assign wbIsLoad                 = wb_is_load_q;
    assign memFault                 = mem_fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed plus randomized bench for mem_access_ctrl. A word-array memory sits
// on the DUT's memory port; a separate reference array tracks what every load
// must return, and each request's completion record is derived from the
// request alone (fault / store / load of the reference word).
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
);

    localparam int unsigned ADDR_DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        reqWrite;
    logic [2:0]  reqDest;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic        CONTROL_MEM_ACCESS;
    logic        CONTROL_ENABLE_MEM_WRITE;
    logic [31:0] memRData;
    logic        wbValid;
    logic        wbReady;
    logic [31:0] wbData;
    logic [2:0]  wbDest;
    logic        wbIsLoad;
    logic        memFault;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .reqValid                (reqValid),
        .reqReady                (reqReady),
        .reqAddr                 (reqAddr),
        .reqData                 (reqData),
        .reqWrite                (reqWrite),
        .reqDest                 (reqDest),
        .memAddr                 (memAddr),
        .memWData                (memWData),
        .CONTROL_MEM_ACCESS      (CONTROL_MEM_ACCESS),
        .CONTROL_ENABLE_MEM_WRITE(CONTROL_ENABLE_MEM_WRITE),
        .memRData                (memRData),
        .wbValid                 (wbValid),
        .wbReady                 (wbReady),
        .wbData                  (wbData),
        .wbDest                  (wbDest),
        .wbIsLoad                (wbIsLoad),
        .memFault                (memFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 10) return 32'd5;
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Data memory: reads only return real data while a read strobe is up.
    logic [31:0] dmem [ADDR_DEPTH];
    assign memRData = (CONTROL_MEM_ACCESS === 1'b1 && CONTROL_ENABLE_MEM_WRITE === 1'b0
                       && memAddr < 32'(ADDR_DEPTH)) ? dmem[memAddr[5:0]] : 32'hBAD0_BAD0;

    initial begin
        for (int i = 0; i < int'(ADDR_DEPTH); i++) dmem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (CONTROL_MEM_ACCESS === 1'b1 && CONTROL_ENABLE_MEM_WRITE === 1'b1
                && memAddr < 32'(ADDR_DEPTH))
                dmem[memAddr[5:0]] = memWData;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [ADDR_DEPTH];
    bit          in_resp;
    logic [31:0] exp_data;
    logic [2:0]  exp_dest;
    logic        exp_is_load;
    logic        exp_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_record(input string tag);
        check({tag, "_wbValid"},  32'(wbValid),  32'd1);
        check({tag, "_wbData"},   wbData,        exp_data);
        check({tag, "_wbDest"},   32'(wbDest),   32'(exp_dest));
        check({tag, "_wbIsLoad"}, 32'(wbIsLoad), 32'(exp_is_load));
        check({tag, "_memFault"}, 32'(memFault), 32'(exp_fault));
        check({tag, "_strobe"},   32'(CONTROL_MEM_ACCESS), 32'd0);
        check({tag, "_wen"},      32'(CONTROL_ENABLE_MEM_WRITE), 32'd0);
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic expect_access(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic [2:0] dst);
        bit fault;
        fault = (a >= 32'(ADDR_DEPTH));
        if (!fault) begin
            for (int k = 0; k < int'(WAIT_CYCLES); k++) begin
                check("acc_strobe",   32'(CONTROL_MEM_ACCESS), 32'd1);
                check("acc_wen",      32'(CONTROL_ENABLE_MEM_WRITE), 32'(w));
                check("acc_memAddr",  memAddr, a);
                check("acc_memWData", memWData, d);
                check("acc_wbValid",  32'(wbValid), 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
        end
        exp_fault   = fault;
        exp_dest    = dst;
        exp_is_load = !w;
        if (fault || w) exp_data = 32'd0;
        else            exp_data = ref_mem[a[5:0]];
        if (!fault && w) ref_mem[a[5:0]] = d;
        in_resp = 1'b1;
        check_record("done");
    endtask

    // Present a request at a negedge; if a record is pending, stall it for hold cycles first.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [2:0] dst, input int hold);
        reqValid = 1'b1;
        reqAddr  = a;
        reqData  = d;
        reqWrite = w;
        reqDest  = dst;
        wbReady  = 1'b0;
        #1;
        if (in_resp) begin
            for (int h = 0; h < hold; h++) begin
                check("bp_reqReady", 32'(reqReady), 32'd0);
                check_record("bp");
                @(posedge clk);
                @(negedge clk);
            end
            wbReady = 1'b1;
            #1;
        end
        check("reqReady", 32'(reqReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        wbReady  = 1'b0;
        reqAddr  = $urandom;
        reqData  = $urandom;
        reqWrite = 1'($urandom);
        reqDest  = 3'($urandom);
        expect_access(a, d, w, dst);
    endtask

    task automatic drain(input int hold);
        for (int h = 0; h < hold; h++) begin
            check_record("hold");
            @(posedge clk);
            @(negedge clk);
        end
        wbReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wbReady = 1'b0;
        #1;
        check("drain_wbValid",  32'(wbValid), 32'd0);
        check("drain_reqReady", 32'(reqReady), 32'd1);
        in_resp = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        for (int i = 0; i < int'(ADDR_DEPTH); i++) ref_mem[i] = init_word(i);
        in_resp     = 1'b0;
        exp_data    = '0;
        exp_dest    = '0;
        exp_is_load = 1'b0;
        exp_fault   = 1'b0;
        rst_n    = 1'b0;
        reqValid = 1'b0;
        reqAddr  = '0;
        reqData  = '0;
        reqWrite = 1'b0;
        reqDest  = '0;
        wbReady  = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_reqReady", 32'(reqReady), 32'd0);
        check("rst_wbValid",  32'(wbValid),  32'd0);
        check("rst_wbData",   wbData,        32'd0);
        check("rst_wbDest",   32'(wbDest),   32'd0);
        check("rst_wbIsLoad", 32'(wbIsLoad), 32'd0);
        check("rst_memFault", 32'(memFault), 32'd0);
        check("rst_memAddr",  memAddr,       32'd0);
        check("rst_memWData", memWData,      32'd0);
        check("rst_strobe",   32'(CONTROL_MEM_ACCESS), 32'd0);
        check("rst_wen",      32'(CONTROL_ENABLE_MEM_WRITE), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_reqReady", 32'(reqReady), 32'd1);
        @(negedge clk);

        // Load of a known word.
        issue(32'd10, 32'h0, 1'b0, 3'd3, 0);
        check("tp_load_data", wbData, 32'd5);
        check("tp_load_dest", 32'(wbDest), 32'd3);
        drain(0);

        // Store then load of the same word.
        issue(32'd11, 32'hDEAD_BEEF, 1'b1, 3'd1, 0);
        check("tp_store_data", wbData, 32'd0);
        drain(0);
        issue(32'd11, 32'h0, 1'b0, 3'd2, 0);
        check("tp_reload_data", wbData, 32'hDEAD_BEEF);
        drain(1);

        // Out-of-range addresses, including the boundary and the top of the space.
        issue(32'd64, 32'h1111_2222, 1'b0, 3'd4, 0);
        check("tp_fault64", 32'(memFault), 32'd1);
        drain(0);
        issue(32'hFFFF_FFFF, 32'h1234, 1'b1, 3'd5, 0);
        check("tp_faultmax_isload", 32'(wbIsLoad), 32'd0);
        drain(2);
        issue(32'd63, 32'h0, 1'b0, 3'd0, 0);
        check("tp_last_word_fault", 32'(memFault), 32'd0);
        drain(0);

        // Backpressure for 5 cycles, then back-to-back accept on the handshake edge.
        issue(32'd20, 32'h0, 1'b0, 3'd6, 0);
        issue(32'd21, 32'hCAFE_F00D, 1'b1, 3'd7, 5);
        issue(32'd100, 32'h0, 1'b0, 3'd2, 2);
        issue(32'd21, 32'h0, 1'b0, 3'd1, 0);
        check("tp_b2b_reload", wbData, 32'hCAFE_F00D);
        drain(0);

        // Reset while a load is in flight.
        reqValid = 1'b1;
        reqAddr  = 32'd10;
        reqData  = 32'h0;
        reqWrite = 1'b0;
        reqDest  = 3'd3;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check("midrst_strobe_before", 32'(CONTROL_MEM_ACCESS), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_strobe",   32'(CONTROL_MEM_ACCESS), 32'd0);
        check("midrst_wbValid",  32'(wbValid), 32'd0);
        check("midrst_reqReady", 32'(reqReady), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < int'(WAIT_CYCLES) + 3; k++) begin
            #1;
            check("postrst_wbValid",  32'(wbValid), 32'd0);
            check("postrst_reqReady", 32'(reqReady), 32'd1);
            check("postrst_strobe",   32'(CONTROL_MEM_ACCESS), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       a = 32'($urandom_range(0, ADDR_DEPTH - 1));
            else if (r == 8) a = 32'(ADDR_DEPTH) + 32'($urandom_range(0, 1000));
            else             a = $urandom;
            d = $urandom;
            issue(a, d, 1'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) drain(int'($urandom_range(0, 3)));
        end
        if (in_resp) drain(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
